ow_multi_master: RTL and testbench

OW_MULTI_MASTER -- requirements
Module: ow_multi_master

---
 rtl/ow_multi_master.sv | 225 ++++++++++++++++++++++
 tb/tb_ow_multi_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ow_multi_master.sv
// ow_multi_master
//   Drives CH independent 1-Wire lines in lock-step. One command runs on every
//   enabled line at once: reset/presence, write byte, read byte or CRC clear.
//   Bit timing is based on a 1 us tick derived from clk by a TICK_DIV prescaler.
//
// Parameters
//   CH        number of 1-Wire lines (1..16)
//   TICK_DIV  clk cycles per 1 us tick (>= 1)
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_op              00 reset/presence, 01 write byte, 10 read byte, 11 CRC clear
//   cmd_data            byte written to all enabled lines, LSB first
//   cmd_mask            per-line enable; masked lines are never pulled
//   ow_in               raw line levels (double-flop synchronised inside)
//   ow_pull             registered pull-down enables (1 = drive low)
//   rsp_valid           one-cycle pulse when a command completes
//   rsp_data            read byte per line, line k in [8k+7:8k]
//   presence            presence detected per line on the last reset op
//   busy                high from acceptance through the rsp_valid cycle
//   crc_zero            per-line running Dallas CRC8 equals 0x00
//
// Optional feature
//   OW_MULTI_MASTER_CRC8_EN  enables per-line CRC8 (x^8+x^5+x^4+1) over read
//                            bits; when undefined crc_zero is tied to 0.

module ow_multi_master #(
  parameter int CH       = 4,
  parameter int TICK_DIV = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [7:0]      cmd_data,
  input  logic [CH-1:0]   cmd_mask,
  input  logic [CH-1:0]   ow_in,
  output logic [CH-1:0]   ow_pull,
  output logic            rsp_valid,
  output logic [8*CH-1:0] rsp_data,
  output logic [CH-1:0]   presence,
  output logic            busy,
  output logic [CH-1:0]   crc_zero
);

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, SLOT, DONE} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] OP_RST   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CRC   = 2'b11;

  state_t          state, state_nx;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [8:0]      tcnt;
  logic [2:0]      bitcnt;
  logic [1:0]      op_q;
  logic [7:0]      data_q;
  logic [CH-1:0]   mask_q;
  logic [CH-1:0]   sync1, sync2;
  logic [8*CH-1:0] shift_q;
  logic [CH-1:0]   pull_nx;
  logic            accept;
  logic            last_rst;
  logic            last_slot;
  logic            read_sample;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == DONE);
  assign accept      = cmd_valid && cmd_ready;
  assign tick        = (presc == PRESC_MAX);
  assign last_rst    = tick && (tcnt == 9'd479);
  assign last_slot   = tick && (tcnt == 9'd63);
  assign read_sample = (state == SLOT) && (op_q == OP_READ) && tick && (tcnt == 9'd14);

  // Next-state and next pull pattern. The pull pattern is derived only from
  // registered state so ow_pull has no path from the command inputs.
  always_comb begin
    state_nx = state;
    pull_nx  = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RST:  state_nx = RST_LOW;
            OP_CRC:  state_nx = DONE;
            default: state_nx = SLOT;
          endcase
        end
      end
      RST_LOW: begin
        pull_nx = mask_q;
        if (last_rst) state_nx = RST_WAIT;
      end
      RST_WAIT: begin
        if (last_rst) state_nx = DONE;
      end
      SLOT: begin
        // Every slot starts with a 2-tick low; a written 0 stretches it to 60.
        if ((tcnt < 9'd2) ||
            ((op_q == OP_WRITE) && !data_q[bitcnt] && (tcnt < 9'd60)))
          pull_nx = mask_q;
        if (last_slot && (bitcnt == 3'd7)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ow_pull <= '0;
    end else begin
      state   <= state_nx;
      ow_pull <= pull_nx;
    end
  end

  // Prescaler, tick timer and bit counter; all restart on acceptance so the
  // first tick of every command is a full tick long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      tcnt   <= '0;
      bitcnt <= '0;
    end else begin
      if (accept || tick) presc <= '0;
      else                presc <= presc + PW'(1);

      if (accept || (state == IDLE))
        tcnt <= '0;
      else if (tick) begin
        if (((state == RST_LOW) || (state == RST_WAIT)) && (tcnt == 9'd479))
          tcnt <= '0;
        else if ((state == SLOT) && (tcnt == 9'd63))
          tcnt <= '0;
        else
          tcnt <= tcnt + 9'd1;
      end

      if (accept)                          bitcnt <= '0;
      else if ((state == SLOT) && last_slot) bitcnt <= bitcnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      data_q <= '0;
      mask_q <= '0;
      sync1  <= '1;
      sync2  <= '1;
    end else begin
      sync1 <= ow_in;
      sync2 <= sync1;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        mask_q <= cmd_mask;
      end
    end
  end

  // Read bits enter at bit 7 so the first (LSB) bit ends up in bit 0. The
  // finished byte is copied out on the last slot edge so rsp_data is already
  // valid during the rsp_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      rsp_data <= '0;
      presence <= '0;
    end else begin
      if (read_sample) begin
        for (int k = 0; k < CH; k++)
          if (mask_q[k]) shift_q[8*k +: 8] <= {sync2[k], shift_q[8*k+1 +: 7]};
      end
      if ((state == SLOT) && (op_q == OP_READ) && last_slot && (bitcnt == 3'd7)) begin
        for (int k = 0; k < CH; k++)
          if (mask_q[k]) rsp_data[8*k +: 8] <= shift_q[8*k +: 8];
      end
      if (accept && (cmd_op == OP_RST))
        presence <= '0;
      else if ((state == RST_WAIT) && tick && (tcnt == 9'd70))
        presence <= mask_q & ~sync2;
    end
  end

`ifdef OW_MULTI_MASTER_CRC8_EN
  logic [8*CH-1:0] crc_q;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc_q <= '0;
    else if (accept && ((cmd_op == OP_CRC) || (cmd_op == OP_RST)))
      crc_q <= '0;
    else if (read_sample) begin
      for (int k = 0; k < CH; k++)
        if (mask_q[k]) crc_q[8*k +: 8] <= crc_step(crc_q[8*k +: 8], sync2[k]);
    end
  end

  always_comb begin
    crc_zero = '0;
    for (int k = 0; k < CH; k++)
      crc_zero[k] = (crc_q[8*k +: 8] == 8'h00);
  end
`else
  assign crc_zero = '0;
`endif

endmodule

// File: tb/tb_ow_multi_master.sv
// tb_ow_multi_master
//   Directed bench for ow_multi_master with CH=2, TICK_DIV=4 (one tick = 4 clk).
//   Lines are modelled as wired-AND: a line reads low when the master pulls it
//   or when the bench slave model holds it low.

module tb_ow_multi_master;

  localparam int CH = 2;
  localparam int TD = 4;
`ifdef OW_MULTI_MASTER_CRC8_EN
  localparam logic [1:0] CRC_ZERO_RST = 2'b11;
`else
  localparam logic [1:0] CRC_ZERO_RST = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [1:0]  cmd_mask;
  logic [1:0]  ow_in;
  logic [1:0]  ow_pull;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  presence;
  logic        busy;
  logic [1:0]  crc_zero;

  int n_cmp = 0;
  int n_err = 0;

  // Slave model on line 0: after each master falling edge, hold the line low
  // for 30 ticks when the bit being returned is 0.
  logic       slave_en   = 1'b0;
  logic [7:0] slave_byte = 8'hFF;
  logic       pres_low   = 1'b0;
  logic       rd_low     = 1'b0;
  logic       pull0_q    = 1'b0;
  int         slave_idx  = 0;
  int         low_cnt    = 0;

  assign ow_in = ~(ow_pull | {1'b0, rd_low | pres_low});

  ow_multi_master #(.CH(CH), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .ow_in(ow_in), .ow_pull(ow_pull),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .presence(presence),
    .busy(busy), .crc_zero(crc_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pull0_q <= ow_pull[0];
    if (!slave_en) begin
      slave_idx <= 0;
      low_cnt   <= 0;
      rd_low    <= 1'b0;
    end else if (ow_pull[0] && !pull0_q) begin
      if (!slave_byte[slave_idx[2:0]]) begin
        rd_low  <= 1'b1;
        low_cnt <= 30 * TD;
      end
      slave_idx <= slave_idx + 1;
    end else if (low_cnt != 0) begin
      low_cnt <= low_cnt - 1;
      if (low_cnt == 1) rd_low <= 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [1:0] mask);
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; cmd_mask = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++; if (ow_pull !== 2'b00)  begin n_err++; $display("[TB] FAIL reset_pull: got %b, expected 00", ow_pull); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    n_cmp++; if (presence !== 2'b00) begin n_err++; $display("[TB] FAIL reset_presence: got %b, expected 00", presence); end
    n_cmp++; if (rsp_data !== 16'h0) begin n_err++; $display("[TB] FAIL reset_rsp_data: got %h, expected 0000", rsp_data); end
    n_cmp++; if (crc_zero !== CRC_ZERO_RST) begin n_err++; $display("[TB] FAIL reset_crc_zero: got %b, expected %b", crc_zero, CRC_ZERO_RST); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
  endtask

  // Presence: line 0 answers low during RST_WAIT ticks 60..200, line 1 stays high.
  task automatic test_presence();
    int  cnt;
    bit  seen;
    bit  busy_ok;
    issue(2'b00, 8'h00, 2'b11);
    cnt = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cnt < 4200) begin
      @(negedge clk);
      cnt++;
      if (cnt == 480*TD + 60*TD)  pres_low = 1'b1;
      if (cnt == 480*TD + 201*TD) pres_low = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (rsp_valid) seen = 1'b1;
    end
    pres_low = 1'b0;
    n_cmp++; if (!seen) begin n_err++; $display("[TB] FAIL presence_rsp: got no rsp_valid, expected one within 4200 cycles"); end
    n_cmp++; if (cnt < 3838 || cnt > 3842) begin n_err++; $display("[TB] FAIL presence_latency: got %0d cycles, expected 3840", cnt); end
    n_cmp++; if (!busy_ok) begin n_err++; $display("[TB] FAIL presence_busy: got busy low during op, expected high"); end
    n_cmp++; if (presence !== 2'b01) begin n_err++; $display("[TB] FAIL presence_value: got %b, expected 01", presence); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL presence_pulse_width: got %b, expected 0", rsp_valid); end
  endtask

  // Write 0xA5 on line 0 only; low pulses 2,60,2,60,60,2,60,2 ticks.
  task automatic test_write();
    int  lens [8];
    int  exp_t [8];
    int  npulse;
    int  run;
    int  cnt;
    bit  seen;
    bit  line1_pulled;
    exp_t = '{2, 60, 2, 60, 60, 2, 60, 2};
    for (int i = 0; i < 8; i++) lens[i] = 0;
    npulse = 0; run = 0; cnt = 0; seen = 1'b0; line1_pulled = 1'b0;
    issue(2'b01, 8'hA5, 2'b01);
    while (!seen && cnt < 2300) begin
      @(negedge clk);
      cnt++;
      if (ow_pull[1]) line1_pulled = 1'b1;
      if (ow_pull[0]) run++;
      else if (run > 0) begin
        if (npulse < 8) lens[npulse] = run;
        npulse++;
        run = 0;
      end
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("[TB] FAIL write_rsp: got no rsp_valid, expected one"); end
    n_cmp++; if (npulse != 8) begin n_err++; $display("[TB] FAIL write_pulse_count: got %0d, expected 8", npulse); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (lens[i] != exp_t[i]*TD) begin
        n_err++; $display("[TB] FAIL write_pulse_len[%0d]: got %0d clk, expected %0d clk", i, lens[i], exp_t[i]*TD);
      end
    end
    n_cmp++; if (line1_pulled) begin n_err++; $display("[TB] FAIL write_masked_line: got ow_pull[1]=1, expected always 0"); end
  endtask

  task automatic read_byte(input logic [7:0] b, input logic [1:0] mask, output bit seen);
    int cnt;
    slave_byte = b;
    slave_en   = 1'b1;
    issue(2'b10, 8'h00, mask);
    wait_rsp(2300, cnt, seen);
    slave_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    bit seen;
    read_byte(8'h28, 2'b11, seen);
    n_cmp++; if (!seen) begin n_err++; $display("[TB] FAIL read_rsp: got no rsp_valid, expected one"); end
    n_cmp++; if (rsp_data !== 16'hFF28) begin n_err++; $display("[TB] FAIL read_data: got %h, expected ff28", rsp_data); end
`ifndef OW_MULTI_MASTER_CRC8_EN
    n_cmp++; if (crc_zero !== 2'b00) begin n_err++; $display("[TB] FAIL read_crc_tied: got %b, expected 00", crc_zero); end
`endif
  endtask

  task automatic test_crc();
    int cnt;
    bit seen;
    issue(2'b11, 8'h00, 2'b11);
    wait_rsp(5, cnt, seen);
    n_cmp++; if (!seen) begin n_err++; $display("[TB] FAIL crc_clear_rsp: got no rsp_valid, expected one within 5 cycles"); end
    n_cmp++; if (cnt != 1) begin n_err++; $display("[TB] FAIL crc_clear_latency: got %0d, expected 1", cnt); end
`ifdef OW_MULTI_MASTER_CRC8_EN
    n_cmp++; if (crc_zero !== 2'b11) begin n_err++; $display("[TB] FAIL crc_after_clear: got %b, expected 11", crc_zero); end
    read_byte(8'h01, 2'b01, seen);
    n_cmp++; if (crc_zero !== 2'b10) begin n_err++; $display("[TB] FAIL crc_after_01: got %b, expected 10", crc_zero); end
    read_byte(8'h5E, 2'b01, seen);
    n_cmp++; if (rsp_data[7:0] !== 8'h5E) begin n_err++; $display("[TB] FAIL crc_read_5e: got %h, expected 5e", rsp_data[7:0]); end
    n_cmp++; if (crc_zero !== 2'b11) begin n_err++; $display("[TB] FAIL crc_after_5e: got %b, expected 11", crc_zero); end
    issue(2'b11, 8'h00, 2'b11);
    wait_rsp(5, cnt, seen);
    read_byte(8'h01, 2'b01, seen);
    read_byte(8'h5F, 2'b01, seen);
    n_cmp++; if (crc_zero !== 2'b10) begin n_err++; $display("[TB] FAIL crc_after_5f: got %b, expected 10", crc_zero); end
`endif
  endtask

  // cmd_valid held high (with changing op/data) while a write of 0x0F runs.
  task automatic test_back_to_back();
    int  cnt;
    int  pulses;
    int  rises;
    int  longs;
    int  run;
    logic prev;
    @(negedge clk);
    cmd_op = 2'b01; cmd_data = 8'h0F; cmd_mask = 2'b01; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = 2'b10; cmd_data = 8'h00;
    pulses = 0; rises = 0; longs = 0; run = 0; prev = 1'b0;
    for (cnt = 0; cnt < 2400; cnt++) begin
      @(negedge clk);
      if (cnt == 1000) cmd_valid = 1'b0;
      if (rsp_valid) pulses++;
      if (ow_pull[0] && !prev) rises++;
      if (ow_pull[0]) run++;
      else begin
        if (run > 100) longs++;
        run = 0;
      end
      prev = ow_pull[0];
    end
    cmd_valid = 1'b0;
    n_cmp++; if (pulses != 1) begin n_err++; $display("[TB] FAIL b2b_rsp_count: got %0d, expected 1", pulses); end
    n_cmp++; if (rises != 8) begin n_err++; $display("[TB] FAIL b2b_slot_count: got %0d, expected 8", rises); end
    n_cmp++; if (longs != 4) begin n_err++; $display("[TB] FAIL b2b_zero_bits: got %0d, expected 4", longs); end
  endtask

  // rst_n asserted during write slot 3 (a 0 bit, so the line is pulled).
  task automatic test_mid_reset();
    int cnt;
    int pulses;
    bit seen;
    issue(2'b01, 8'h00, 2'b01);
    repeat (3*64*TD + 10*TD) @(negedge clk);
    n_cmp++; if (ow_pull[0] !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_pull_before: got %b, expected 1", ow_pull[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ow_pull !== 2'b00) begin n_err++; $display("[TB] FAIL midrst_pull_after: got %b, expected 00", ow_pull); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_cmd_ready: got %b, expected 1", cmd_ready); end
    pulses = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("[TB] FAIL midrst_no_rsp: got %0d pulses, expected 0", pulses); end
    issue(2'b11, 8'h00, 2'b11);
    wait_rsp(5, cnt, seen);
    n_cmp++; if (!seen) begin n_err++; $display("[TB] FAIL midrst_next_cmd: got no rsp_valid, expected one"); end
  endtask

  initial begin
    test_reset();
    test_presence();
    test_write();
    test_read();
    test_crc();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
